inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 46 ++++
 rtl/inst_fetch.sv | 143 ++++++++++++++
 tb/tb_inst_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the memory fetch port, the redirect inputs and the decode-side
// valid/ready handshake of the fetch stage into one interface.
//   master : the fetch stage (drives imem_addr and the decode outputs)
//   slave  : the environment (memory, pipeline redirect logic, decode)
interface inst_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        exc;
    logic        irq;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] epc;

    modport master (
        output imem_addr,
        input  imem_inst,
        input  branch_valid,
        input  branch_target,
        input  exc,
        input  irq,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output epc
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        output branch_valid,
        output branch_target,
        output exc,
        output irq,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  epc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage with a 2-entry {pc, inst} queue toward decode.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset (PC restarts at 0x80000000)
//   bus    : inst_fetch_if.master
//            imem_addr/imem_inst  - combinational instruction memory port
//            branch_valid/target  - pipeline redirect
//            exc / irq            - exception and level interrupt requests
//            out_valid/ready/inst/pc - decode handshake, head of the queue
//            epc                  - return address captured on interrupt
// Redirect priority is exc > irq > branch > sequential; any taken redirect
// flushes the queue. PC bit 31 is the kernel bit and is preserved by the
// sequential increment; interrupts are masked while it is set.
module inst_fetch (
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.master bus
);

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_PC   = 32'h8000_0004;
    localparam logic [31:0] EXC_PC   = 32'h8000_0008;

    // Sequential increment keeps the kernel bit and wraps the low 31 bits.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        pc_inc = {pc[31], pc[30:0] + 31'd4};
    endfunction

    logic [31:0] pc_r,       pc_n_s;
    logic [31:0] epc_r,      epc_n_s;
    logic [1:0]  count_r,    count_n_s;
    logic [31:0] e0_pc_r,    e0_pc_n_s;
    logic [31:0] e0_inst_r,  e0_inst_n_s;
    logic [31:0] e1_pc_r,    e1_pc_n_s;
    logic [31:0] e1_inst_r,  e1_inst_n_s;

    logic        out_valid_s;
    logic        pop_s;
    logic        irq_take_s;
    logic        fetch_s;
    logic        slot1_s;

    // Handshake and fetch qualification.
    always_comb begin
        out_valid_s = (count_r != 2'd0);
        pop_s       = out_valid_s & bus.out_ready;
        irq_take_s  = bus.irq & ~pc_r[31];
        // Only reached when no redirect is taken; room exists or one leaves.
        fetch_s     = (count_r != 2'd2) | pop_s;
        // Write slot for the new entry after an optional shift of the head.
        if (pop_s) begin
            slot1_s = (count_r == 2'd2);
        end else begin
            slot1_s = (count_r == 2'd1);
        end
    end

    // Next-state for PC, epc and the queue.
    always_comb begin
        pc_n_s      = pc_r;
        epc_n_s     = epc_r;
        count_n_s   = count_r;
        e0_pc_n_s   = e0_pc_r;
        e0_inst_n_s = e0_inst_r;
        e1_pc_n_s   = e1_pc_r;
        e1_inst_n_s = e1_inst_r;

        if (bus.exc) begin
            pc_n_s    = EXC_PC;
            count_n_s = 2'd0;
        end else if (irq_take_s) begin
            pc_n_s    = IRQ_PC;
            count_n_s = 2'd0;
            // Return to the oldest instruction not yet handed to decode.
            if (out_valid_s) begin
                epc_n_s = e0_pc_r;
            end else begin
                epc_n_s = pc_r;
            end
        end else if (bus.branch_valid) begin
            pc_n_s    = {bus.branch_target[31:2], 2'b00};
            count_n_s = 2'd0;
        end else if (fetch_s) begin
            pc_n_s = pc_inc(pc_r);
            if (pop_s) begin
                e0_pc_n_s   = e1_pc_r;
                e0_inst_n_s = e1_inst_r;
            end else begin
                count_n_s = count_r + 2'd1;
            end
            case (slot1_s)
                1'b0: begin
                    e0_pc_n_s   = pc_r;
                    e0_inst_n_s = bus.imem_inst;
                end
                1'b1: begin
                    e1_pc_n_s   = pc_r;
                    e1_inst_n_s = bus.imem_inst;
                end
                default: begin
                    e0_pc_n_s   = pc_r;
                    e0_inst_n_s = bus.imem_inst;
                end
            endcase
        end else if (pop_s) begin
            // Unreachable with a 2-entry queue (pop always allows a fetch),
            // kept so a pop can never be silently lost.
            e0_pc_n_s   = e1_pc_r;
            e0_inst_n_s = e1_inst_r;
            count_n_s   = count_r - 2'd1;
        end else begin
            count_n_s = count_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r      <= RESET_PC;
            epc_r     <= 32'd0;
            count_r   <= 2'd0;
            e0_pc_r   <= 32'd0;
            e0_inst_r <= 32'd0;
            e1_pc_r   <= 32'd0;
            e1_inst_r <= 32'd0;
        end else begin
            pc_r      <= pc_n_s;
            epc_r     <= epc_n_s;
            count_r   <= count_n_s;
            e0_pc_r   <= e0_pc_n_s;
            e0_inst_r <= e0_inst_n_s;
            e1_pc_r   <= e1_pc_n_s;
            e1_inst_r <= e1_inst_n_s;
        end
    end

    assign bus.imem_addr = pc_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_inst  = e0_inst_r;
    assign bus.out_pc    = e0_pc_r;
    assign bus.epc       = epc_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] key;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Combinational instruction memory: contents derived from the address.
    assign bus.imem_inst = bus.imem_addr ^ key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc  = 32'h8000_0000;
        m_epc = 32'd0;
    endtask

    // Reference behaviour of one clock edge given the inputs of that cycle.
    task automatic model_step(input logic bv, input logic [31:0] bt,
                              input logic e, input logic i, input logic rdy);
        ent_t n;
        if (e) begin
            m_pc = 32'h8000_0008;
            q.delete();
        end else if (i && (m_pc < 32'h8000_0000)) begin
            m_epc = (q.size() != 0) ? q[0].pc : m_pc;
            m_pc  = 32'h8000_0004;
            q.delete();
        end else if (bv) begin
            m_pc = bt & 32'hFFFF_FFFC;
            q.delete();
        end else begin
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (q.size() < 2) begin
                n.pc   = m_pc;
                n.inst = m_pc ^ key;
                q.push_back(n);
                if (m_pc >= 32'h8000_0000)
                    m_pc = 32'h8000_0000 + ((m_pc - 32'h8000_0000 + 32'd4) % 32'h8000_0000);
                else
                    m_pc = (m_pc + 32'd4) % 32'h8000_0000;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_inst", bus.out_inst, q[0].inst);
        end
        chk("epc", bus.epc, m_epc);
    endtask

    // One clock: apply inputs at the falling edge, advance model, check at next falling edge.
    task automatic cyc(input logic bv, input logic [31:0] bt,
                       input logic e, input logic i, input logic rdy);
        bus.branch_valid  = bv;
        bus.branch_target = bt;
        bus.exc           = e;
        bus.irq           = i;
        bus.out_ready     = rdy;
        model_step(bv, bt, e, i, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_state();
        chk("rst_imem_addr", bus.imem_addr, 32'h8000_0000);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_epc", bus.epc, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        key    = 32'hA5A5_A5A5;
        reset  = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 32'd0;
        bus.exc           = 1'b0;
        bus.irq           = 1'b0;
        bus.out_ready     = 1'b0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        reset = 1'b1;

        // Reset release streaming with decode always ready.
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("seq0_pc", bus.out_pc, 32'h8000_0000);
        chk("seq0_inst", bus.out_inst, 32'h25A5_A5A5);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("seq1_pc", bus.out_pc, 32'h8000_0004);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("seq2_pc", bus.out_pc, 32'h8000_0008);
        chk("seq2_inst", bus.out_inst, 32'h25A5_A5AD);

        // Branch to 0, then stall decode for 5 cycles.
        cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stall_pc", bus.imem_addr, 32'h0000_0008);
        chk("stall_head", bus.out_pc, 32'h0000_0000);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("drain1", bus.out_pc, 32'h0000_0004);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("drain2", bus.out_pc, 32'h0000_0008);

        // Branch with queue full: one empty cycle then the aligned target.
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0027, 1'b0, 1'b0, 1'b1);
        chk("br_bubble", {31'd0, bus.out_valid}, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("br_target", bus.out_pc, 32'h0000_0024);

        // Interrupt at user PC 0x10 with head 0xC, then held in kernel mode.
        cyc(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("irq_epc", bus.epc, 32'h0000_000C);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("irq_vec", bus.out_pc, 32'h8000_0004);
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("irq_masked_epc", bus.epc, 32'h0000_000C);

        // All three redirects at once from user mode.
        cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
        chk("exc_pc", bus.imem_addr, 32'h8000_0008);
        chk("exc_epc", bus.epc, 32'h0000_000C);

        // Kernel-bit preserving wrap.
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("kwrap", bus.imem_addr, 32'h8000_0000);

        // Randomized phase.
        key = $urandom;
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end

        // User wrap, then reset in the middle of a stall.
        cyc(1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("uwrap", bus.imem_addr, 32'h0000_0000);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(negedge clk);
        bus.out_ready = 1'b1;
        reset = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_pc", bus.out_pc, 32'h8000_0000);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
